// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream and instruction-memory write bundle for the boot loader
`timescale 1ns/1ps

interface imem_loader_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    modport master (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata, busy, done, err, word_count
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata, busy, done, err, word_count
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream to instruction-memory word writer
// Optional trailing checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps

module imem_loader #(
    parameter int ADDR_W = 12
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_DATA,
        S_FLUSH,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);

    state_t            state;
    logic [7:0]        len_lo;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   count;
    logic [1:0]        lane;
    logic [23:0]       part;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    logic        ready;
    logic        accept;
    logic [16:0] len_full;
    logic        last_word;

    // Ready is decoded from state but forced low while reset is held.
    assign ready     = !rst && (state == S_IDLE || state == S_LEN_HI ||
                                state == S_DATA || state == S_CSUM);
    assign accept    = bus.in_valid && ready;
    assign len_full  = {1'b0, bus.in_data, len_lo};
    assign last_word = (count + CNT_ONE) == n_words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            len_lo  <= '0;
            n_words <= '0;
            count   <= '0;
            lane    <= '0;
            part    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum     <= '0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        len_lo <= bus.in_data;
                        busy_q <= 1'b1;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        if (len_full == 17'd0 || len_full > MAX_WORDS) begin
                            busy_q <= 1'b0;
                            err_q  <= 1'b1;
                            state  <= S_ERR;
                        end else begin
                            n_words <= len_full[ADDR_W:0];
                            lane    <= '0;
                            count   <= '0;
                            state   <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum  <= sum + bus.in_data;
`endif
                        lane <= lane + 2'd1;
                        if (lane != 2'd3) begin
                            part <= {bus.in_data, part[23:8]};
                        end else begin
                            we_q    <= 1'b1;
                            waddr_q <= count[ADDR_W-1:0];
                            wdata_q <= {bus.in_data, part};
                            count   <= (count == n_words) ? count : count + CNT_ONE;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state <= S_FLUSH;
`endif
                            end
                        end
                    end
                end
                // One cycle after the final write so done trails the last strobe.
                S_FLUSH: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= S_DONE;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        busy_q <= 1'b0;
                        if (8'(sum + bus.in_data) == 8'd0) begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            err_q  <= 1'b1;
                            state  <= S_ERR;
                        end
                    end
                end
`endif
                S_DONE: state <= S_DONE;
                S_ERR:  state <= S_ERR;
                default: begin
                    busy_q <= 1'b0;
                    err_q  <= 1'b1;
                    state  <= S_ERR;
                end
            endcase
        end
    end

    assign bus.in_ready   = ready;
    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.word_count = count;
endmodule
